// File: rtl/neuron_layer_sequencer.sv
// Time-multiplexes one shared 2-input neuron datapath across NUM_NEURONS logical neurons,
// issuing each neuron's operands in turn and streaming results out in index order.
module neuron_layer_sequencer #(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = 2,
  parameter int DP_LATENCY  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_addr,
  input  logic [7:0]              cfg_w1,
  input  logic [7:0]              cfg_w2,
  input  logic [7:0]              cfg_b,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_x1,
  input  logic [7:0]              in_x2,
  output logic [7:0]              dp_x1,
  output logic [7:0]              dp_x2,
  output logic [7:0]              dp_w1,
  output logic [7:0]              dp_w2,
  output logic [7:0]              dp_b,
  input  logic [15:0]             dp_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_y,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    busy
);

  localparam int CNT_W = $clog2(DP_LATENCY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DP_LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    EMIT
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;

  logic [7:0] tbl_w1 [NUM_NEURONS];
  logic [7:0] tbl_w2 [NUM_NEURONS];
  logic [7:0] tbl_b  [NUM_NEURONS];

  logic [IDX_W-1:0] next_idx;
  logic             cfg_in_range;

  assign next_idx     = idx + IDX_W'(1);
  assign cfg_in_range = int'(cfg_addr) < NUM_NEURONS;
  assign in_ready     = (state == IDLE);
  assign busy         = (state != IDLE);

  // Table writes land alongside the FSM; operands are copied at issue, so a write to the
  // entry being issued on the same edge only affects later vectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        tbl_w1[i] <= '0;
        tbl_w2[i] <= '0;
        tbl_b[i]  <= '0;
      end
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      dp_x1     <= '0;
      dp_x2     <= '0;
      dp_w1     <= '0;
      dp_w2     <= '0;
      dp_b      <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      if (cfg_we && cfg_in_range) begin
        tbl_w1[cfg_addr] <= cfg_w1;
        tbl_w2[cfg_addr] <= cfg_w2;
        tbl_b[cfg_addr]  <= cfg_b;
      end

      case (state)
        IDLE: begin
          if (in_valid) begin
            dp_x1 <= in_x1;
            dp_x2 <= in_x2;
            dp_w1 <= tbl_w1[0];
            dp_w2 <= tbl_w2[0];
            dp_b  <= tbl_b[0];
            idx   <= '0;
            cnt   <= '0;
            state <= WAIT;
          end
        end

        WAIT: begin
          if (cnt == CNT_DONE) begin
            out_y     <= dp_y;
            out_idx   <= idx;
            out_last  <= (idx == LAST_IDX);
            out_valid <= 1'b1;
            state     <= EMIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Result and operands hold until the consumer takes it.
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= IDLE;
            end else begin
              idx   <= next_idx;
              dp_w1 <= tbl_w1[next_idx];
              dp_w2 <= tbl_w2[next_idx];
              dp_b  <= tbl_b[next_idx];
              cnt   <= '0;
              state <= WAIT;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Directed bench for neuron_layer_sequencer with a 3-stage shared neuron model
// y = ReLU((x1*w1)>>>7 + (x2*w2)>>>7 + b) as the datapath.
module tb_neuron_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [7:0]  cfg_w1 = '0, cfg_w2 = '0, cfg_b = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x1 = '0, in_x2 = '0;
  logic [7:0]  dp_x1, dp_x2, dp_w1, dp_w2, dp_b;
  logic [15:0] dp_y;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_y;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        busy;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  neuron_layer_sequencer #(.NUM_NEURONS(4), .IDX_W(2), .DP_LATENCY(3)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_w1(cfg_w1), .cfg_w2(cfg_w2), .cfg_b(cfg_b),
    .in_valid(in_valid), .in_ready(in_ready), .in_x1(in_x1), .in_x2(in_x2),
    .dp_x1(dp_x1), .dp_x2(dp_x2), .dp_w1(dp_w1), .dp_w2(dp_w2), .dp_b(dp_b),
    .dp_y(dp_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  // Shared neuron: products, then sum with bias, then ReLU -- three edges of latency.
  logic signed [15:0] mP1, mP2;
  logic signed [7:0]  mB;
  logic signed [17:0] mSum;

  always @(posedge clk) begin
    if (rst) begin
      mP1  <= '0;
      mP2  <= '0;
      mB   <= '0;
      mSum <= '0;
      dp_y <= '0;
    end else begin
      mP1  <= ($signed(dp_x1) * $signed(dp_w1)) >>> 7;
      mP2  <= ($signed(dp_x2) * $signed(dp_w2)) >>> 7;
      mB   <= $signed(dp_b);
      mSum <= mP1 + mP2 + mB;
      dp_y <= (mSum < 0) ? 16'd0 : mSum[15:0];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic cfgWrite(input logic [1:0] addr, input logic [7:0] w1, input logic [7:0] w2,
                          input logic [7:0] b);
    cfg_we = 1'b1; cfg_addr = addr; cfg_w1 = w1; cfg_w2 = w2; cfg_b = b;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Runs one vector from IDLE; optional stall, mid-run table write, abort by reset,
  // or continuing to offer a follow-on vector.
  task automatic applyStimulus(input string name, input logic [7:0] x1, input logic [7:0] x2,
                               input logic [63:0] expv, input int stallIdx,
                               input int writeIdx, input logic [1:0] wAddr,
                               input logic [7:0] wW1, input logic [7:0] wW2, input logic [7:0] wB,
                               input int abortIdx, input bit keepValid,
                               input logic [7:0] nx1, input logic [7:0] nx2);
    int cycles;
    logic [15:0] heldY;
    in_valid = 1'b1; in_x1 = x1; in_x2 = x2;
    @(negedge clk);
    if (keepValid) begin
      in_x1 = nx1; in_x2 = nx2;
      checkOutput({name, " in_ready low after accept"}, 32'(in_ready), 32'd0);
    end else begin
      in_valid = 1'b0;
    end
    checkOutput({name, " dp_x1 latched"}, 32'(dp_x1), 32'(x1));
    for (int k = 0; k < 4; k++) begin
      cycles = 0;
      if (k == writeIdx) begin
        cfg_we = 1'b1; cfg_addr = wAddr; cfg_w1 = wW1; cfg_w2 = wW2; cfg_b = wB;
      end
      if (k == abortIdx) begin
        @(negedge clk);
        cfg_we = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput({name, " abort out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({name, " abort busy"}, 32'(busy), 32'd0);
        checkOutput({name, " abort in_ready"}, 32'(in_ready), 32'd1);
        return;
      end
      while (!out_valid && cycles < 20) begin
        @(negedge clk);
        cfg_we = 1'b0;
        cycles++;
      end
      checkOutput($sformatf("%s latency idx%0d", name, k), 32'(cycles), 32'd4);
      checkOutput($sformatf("%s out_y idx%0d", name, k), 32'(out_y), 32'(expv[16*k +: 16]));
      checkOutput($sformatf("%s out_idx idx%0d", name, k), 32'(out_idx), 32'(k));
      checkOutput($sformatf("%s out_last idx%0d", name, k), 32'(out_last), 32'(k == 3));
      if (k == stallIdx) begin
        out_ready = 1'b0;
        heldY = out_y;
        repeat (6) @(negedge clk);
        checkOutput($sformatf("%s stall valid idx%0d", name, k), 32'(out_valid), 32'd1);
        checkOutput($sformatf("%s stall y idx%0d", name, k), 32'(out_y), 32'(heldY));
        checkOutput($sformatf("%s stall idx idx%0d", name, k), 32'(out_idx), 32'(k));
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    checkOutput({name, " busy after last"}, 32'(busy), 32'd0);
    checkOutput({name, " in_ready after last"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_y", 32'(out_y), 32'd0);
    checkOutput("reset out_idx", 32'(out_idx), 32'd0);
    checkOutput("reset out_last", 32'(out_last), 32'd0);

    repeat (10) @(negedge clk);
    checkOutput("idle busy", 32'(busy), 32'd0);
    checkOutput("idle out_valid", 32'(out_valid), 32'd0);
    checkOutput("idle dp_ops", 32'({dp_x1, dp_x2, dp_w1, dp_w2} | {24'd0, dp_b}), 32'd0);

    cfgWrite(2'd0, 8'd64, 8'd64, 8'd0);
    cfgWrite(2'd1, -8'sd64, 8'd0, 8'd10);
    cfgWrite(2'd2, 8'd127, 8'd127, -8'sd1);
    cfgWrite(2'd3, 8'd0, 8'd0, 8'd5);

    applyStimulus("basic", 8'd64, 8'd64, {16'd5, 16'd125, 16'd0, 16'd64},
                  -1, -1, 2'd0, 8'd0, 8'd0, 8'd0, -1, 1'b0, 8'd0, 8'd0);
    applyStimulus("stall", 8'd64, 8'd64, {16'd5, 16'd125, 16'd0, 16'd64},
                  1, -1, 2'd0, 8'd0, 8'd0, 8'd0, -1, 1'b0, 8'd0, 8'd0);
    // N0 rewritten while its own result is in flight: idx 0 still uses the old weights.
    applyStimulus("wrN0", 8'd64, 8'd64, {16'd5, 16'd125, 16'd0, 16'd64},
                  -1, 0, 2'd0, 8'd0, 8'd0, 8'd99, -1, 1'b0, 8'd0, 8'd0);
    applyStimulus("wrN2", 8'd64, 8'd64, {16'd5, 16'd7, 16'd0, 16'd99},
                  -1, 1, 2'd2, 8'd0, 8'd0, 8'd7, -1, 1'b0, 8'd0, 8'd0);

    // Table now N0=(0,0,99) N1=(-64,0,10) N2=(0,0,7) N3=(0,0,5).
    applyStimulus("b2bA", 8'd64, 8'd64, {16'd5, 16'd7, 16'd0, 16'd99},
                  -1, -1, 2'd0, 8'd0, 8'd0, 8'd0, -1, 1'b1, -8'sd64, 8'd100);
    applyStimulus("b2bB", -8'sd64, 8'd100, {16'd5, 16'd7, 16'd42, 16'd99},
                  -1, -1, 2'd0, 8'd0, 8'd0, 8'd0, -1, 1'b0, 8'd0, 8'd0);

    applyStimulus("abort", 8'd64, 8'd64, {16'd5, 16'd7, 16'd0, 16'd99},
                  -1, -1, 2'd0, 8'd0, 8'd0, 8'd0, 2, 1'b0, 8'd0, 8'd0);
    applyStimulus("zeroed", 8'd64, 8'd64, {16'd0, 16'd0, 16'd0, 16'd0},
                  -1, -1, 2'd0, 8'd0, 8'd0, 8'd0, -1, 1'b0, 8'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
